// File: rtl/aes_seq_if.sv
// aes_seq_if: command and strobe bundle between button logic, aes_round_sequencer and the AES datapath
interface aes_seq_if;
  logic start, abort, step_mode, step;
  logic ld_state, ark_en, kexp_en, sub_en, shift_en, mix_en, sbox_sel, busy, done;
  logic [3:0] sbox_grp, round, phase;
  logic [7:0] rcon;
  logic [15:0] cyc_cnt;
  modport master (
    output start, abort, step_mode, step,
    input ld_state, ark_en, kexp_en, sub_en, shift_en, mix_en, sbox_sel, busy, done,
    input sbox_grp, round, phase, rcon, cyc_cnt
  );
  modport slave (
    input start, abort, step_mode, step,
    output ld_state, ark_en, kexp_en, sub_en, shift_en, mix_en, sbox_sel, busy, done,
    output sbox_grp, round, phase, rcon, cyc_cnt
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: AES-128 round control FSM sharing one S-box; AES_SEQ_CYCLE_CNT_EN adds a run-latency counter
module aes_round_sequencer #(
  parameter int NR = 10,
  parameter int BPC = 4
) (
  input logic clk,
  input logic rst,
  aes_seq_if.slave bus
);
  localparam logic [3:0] SUB_LAST = 4'(16 / BPC - 1);
  localparam logic [3:0] KEXP_LAST = 4'((BPC >= 4 ? 1 : 4 / BPC) - 1);
  localparam logic [3:0] LAST_RND = 4'(NR);
  typedef enum logic [3:0] {IDLE, LOAD, ARK0, KEXP, SUB, SHIFT, MIX, ARK, PAUSE, DONE} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  logic final_rnd, kill;
  assign final_rnd = round_q == LAST_RND;
  assign kill = bus.abort && state_q != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      round_q <= '0;
      rcon_q <= 8'h01;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      round_q <= round_d;
      rcon_q <= rcon_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = bus.start ? LOAD : IDLE;
      LOAD: state_d = ARK0;
      ARK0: state_d = bus.step_mode ? PAUSE : KEXP;
      KEXP: state_d = cnt_q == KEXP_LAST ? SUB : KEXP;
      SUB: state_d = cnt_q == SUB_LAST ? SHIFT : SUB;
      SHIFT: state_d = final_rnd ? ARK : MIX;
      MIX: state_d = ARK;
      ARK: state_d = final_rnd ? DONE : bus.step_mode ? PAUSE : KEXP;
      PAUSE: state_d = bus.step ? KEXP : PAUSE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end
  always_comb begin
    cnt_d = (state_d == state_q && (state_q == KEXP || state_q == SUB)) ? cnt_q + 4'd1 : '0;
    round_d = (kill || state_d == LOAD) ? '0 : (state_d == KEXP && state_q != KEXP) ? round_q + 4'd1 : round_q;
    rcon_d = state_d == LOAD ? 8'h01 :
             (state_q == KEXP && state_d == SUB) ? ({rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00)) : rcon_q;
  end
  assign bus.ld_state = state_q == LOAD;
  assign bus.ark_en = state_q == ARK0 || state_q == ARK;
  assign bus.kexp_en = state_q == KEXP;
  assign bus.sub_en = state_q == SUB;
  assign bus.shift_en = state_q == SHIFT;
  assign bus.mix_en = state_q == MIX;
  assign bus.sbox_sel = state_q == KEXP;
  assign bus.sbox_grp = (state_q == KEXP || state_q == SUB) ? cnt_q : '0;
  assign bus.round = round_q;
  assign bus.rcon = rcon_q;
  assign bus.phase = state_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
`ifdef AES_SEQ_CYCLE_CNT_EN
  logic [15:0] cyc_q, cyc_d;
  always_comb cyc_d = (state_q == IDLE && state_d == LOAD) ? '0 :
                      (state_q != IDLE && cyc_q != 16'hFFFF) ? cyc_q + 16'd1 : cyc_q;
  always_ff @(posedge clk) cyc_q <= rst ? '0 : cyc_d;
  assign bus.cyc_cnt = cyc_q;
`else
  assign bus.cyc_cnt = '0;
`endif
endmodule
